audio_sample_fifo: RTL and testbench

AUDIO_SAMPLE_FIFO -- requirements
Module: audio_sample_fifo

---
 rtl/audio_sample_fifo_if.sv | 67 ++++++
 rtl/audio_sample_fifo.sv | 140 ++++++++++++++
 tb/tb_audio_sample_fifo.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_fifo_if.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo_if
//
// Bundles the CPU-side store/control signals and the playback/status outputs
// of audio_sample_fifo.
//
//   master : CPU / bus side. Drives the store strobe, sample data, playback
//            enable and flag clear. Observes duty/tick/status.
//   slave  : FIFO side (audio_sample_fifo).
//
// Signals
//   wr_en       one-cycle store strobe to the audio sample address
//   wr_data     10-bit PWM duty sample (store data bits [9:0])
//   enable      playback enable, gates the sample-rate counter
//   clr_flags   clears sticky underrun/overflow
//   duty_cycle  registered duty value for the PWM serializer
//   sample_tick one-cycle pulse per sample period
//   level       current entry count, clog2(DEPTH)+1 bits
//   full/empty  level == DEPTH / level == 0
//   underrun    sticky: a sample period ended with no data
//   overflow    sticky: a store was dropped because the FIFO was full
// ---------------------------------------------------------------------------
interface audio_sample_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en;
    logic [9:0]    wr_data;
    logic          enable;
    logic          clr_flags;
    logic [9:0]    duty_cycle;
    logic          sample_tick;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          underrun;
    logic          overflow;

    modport master (
        output wr_en,
        output wr_data,
        output enable,
        output clr_flags,
        input  duty_cycle,
        input  sample_tick,
        input  level,
        input  full,
        input  empty,
        input  underrun,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  enable,
        input  clr_flags,
        output duty_cycle,
        output sample_tick,
        output level,
        output full,
        output empty,
        output underrun,
        output overflow
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
//
// Sample buffer between a CPU store port and a PWM audio serializer. The CPU
// pushes 10-bit duty samples; a free-running sample-rate divider pops one
// sample per period into the registered duty_cycle output.
//
// Parameters
//   DEPTH      FIFO entries, power of two, 4..64
//   SAMPLE_DIV clock cycles per output sample, >= 2
//
// Ports
//   clock  system clock, all logic on its rising edge
//   reset  synchronous, active-high; flushes the FIFO and clears all outputs
//   bus    audio_sample_fifo_if.slave (store strobe/data, enable, clr_flags,
//          duty_cycle, sample_tick, level, full, empty, underrun, overflow)
//
// Build option
//   AUDIO_UNDERRUN_MIDSCALE_EN  when defined, an underrun period loads the
//                               silence midpoint (512) into duty_cycle;
//                               otherwise duty_cycle holds its last value.
// ---------------------------------------------------------------------------
module audio_sample_fifo #(
    parameter int DEPTH      = 16,
    parameter int SAMPLE_DIV = 6250
) (
    input  logic                 clock,
    input  logic                 reset,
    audio_sample_fifo_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(SAMPLE_DIV);

    localparam logic [CW-1:0] CNT_MAX    = CW'(SAMPLE_DIV - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

    // Storage and state
    logic [9:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic [CW-1:0] cnt_q;
    logic [9:0]    duty_q;
    logic          tick_q;
    logic          underrun_q;
    logic          overflow_q;

    // Per-edge events
    logic wrap;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic ovf_evt;
    logic und_evt;

    always_comb begin
        wrap    = bus.enable && (cnt_q == CNT_MAX);
        empty   = (level_q == '0);
        full    = (level_q == LEVEL_FULL);
        pop     = wrap && !empty;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push    = bus.wr_en && (!full || pop);
        ovf_evt = bus.wr_en && full && !pop;
        // Empty is judged before this edge's write: a coincident store lands
        // in the FIFO but is not played until the next period.
        und_evt = wrap && empty;
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Sample storage carries no reset; a flush only needs the pointers cleared.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            duty_q     <= '0;
            tick_q     <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            // Divider: held at zero while playback is off.
            if (!bus.enable || wrap) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end

            tick_q <= wrap;

            // Pointers wrap modulo DEPTH by width (DEPTH is a power of two).
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_d;

            if (pop) begin
                duty_q <= mem_q[rd_ptr_q];
            end
`ifdef AUDIO_UNDERRUN_MIDSCALE_EN
            else if (und_evt) begin
                duty_q <= 10'd512;
            end
`endif

            // A new error event on the clearing edge keeps the flag set.
            underrun_q <= und_evt || (underrun_q && !bus.clr_flags);
            overflow_q <= ovf_evt || (overflow_q && !bus.clr_flags);
        end
    end

    assign bus.duty_cycle  = duty_q;
    assign bus.sample_tick = tick_q;
    assign bus.level       = level_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.underrun    = underrun_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_fifo
//
// Bench for audio_sample_fifo with DEPTH=4, SAMPLE_DIV=4. Inputs are driven
// on the falling edge and outputs sampled on the next falling edge. Accepted
// stores are pushed into a scoreboard queue; every sample_tick pops the queue
// and compares duty_cycle, or expects an underrun when the queue is empty.
// ---------------------------------------------------------------------------
module tb_audio_sample_fifo;
    localparam int DEPTH      = 4;
    localparam int SAMPLE_DIV = 4;

`ifdef AUDIO_UNDERRUN_MIDSCALE_EN
    localparam bit MIDSCALE = 1'b1;
`else
    localparam bit MIDSCALE = 1'b0;
`endif

    logic clock;
    logic reset;

    audio_sample_fifo_if #(.DEPTH(DEPTH)) bus ();

    audio_sample_fifo #(
        .DEPTH      (DEPTH),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit         wr;
        logic [9:0] data;
        bit         en;
        bit         clr;
        bit         push;   // store expected to be accepted
        int         lvl;
        bit         tick;
        bit         ovf;
        bit         und;
    } vec_t;

    vec_t vecs[$];
    int   sb[$];
    int   last_duty;
    int   errors;
    int   checks;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string name, input int lvl, input bit tick,
                                input bit ovf, input bit und);
        check({name, ".level"}, int'(bus.level), lvl);
        check({name, ".full"}, int'(bus.full), (lvl == DEPTH) ? 1 : 0);
        check({name, ".empty"}, int'(bus.empty), (lvl == 0) ? 1 : 0);
        check({name, ".tick"}, int'(bus.sample_tick), int'(tick));
        check({name, ".overflow"}, int'(bus.overflow), int'(ovf));
        check({name, ".underrun"}, int'(bus.underrun), int'(und));
    endtask

    // One clock with the given inputs; scoreboard handled after the edge.
    task automatic do_cycle(input bit wr, input logic [9:0] data, input bit en,
                            input bit clr, input bit push);
        bus.wr_en     = wr;
        bus.wr_data   = data;
        bus.enable    = en;
        bus.clr_flags = clr;
        @(negedge clock);
        if (bus.sample_tick) begin
            if (sb.size() != 0) begin
                int e;
                e = sb.pop_front();
                check("duty_pop", int'(bus.duty_cycle), e);
                last_duty = e;
            end else begin
                check("underrun_on_empty_wrap", int'(bus.underrun), 1);
                if (MIDSCALE) last_duty = 512;
                check("duty_on_underrun", int'(bus.duty_cycle), last_duty);
            end
        end
        // Pushed after the tick check: a store on a pop edge queues behind the head.
        if (wr && push) sb.push_back(int'(data));
    endtask

    function automatic void add(bit wr, int data, bit en, bit clr, bit push,
                                int lvl, bit tick, bit ovf, bit und);
        vec_t v;
        v.wr = wr; v.data = 10'(data); v.en = en; v.clr = clr; v.push = push;
        v.lvl = lvl; v.tick = tick; v.ovf = ovf; v.und = und;
        vecs.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        last_duty = 0;

        //              wr  data en clr push lvl tick ovf und
        // Fill with playback off; fifth store is dropped.
        add(1,  11, 0, 0, 1, 1, 0, 0, 0);
        add(1,  22, 0, 0, 1, 2, 0, 0, 0);
        add(1,  33, 0, 0, 1, 3, 0, 0, 0);
        add(1,  44, 0, 0, 1, 4, 0, 0, 0);
        add(1,  55, 0, 0, 0, 4, 0, 1, 0);
        add(0,   0, 0, 0, 0, 4, 0, 1, 0);
        add(0,   0, 0, 1, 0, 4, 0, 0, 0);
        // Enable: first wrap on the 4th enabled edge.
        add(0,   0, 1, 0, 0, 4, 0, 0, 0);
        add(0,   0, 1, 0, 0, 4, 0, 0, 0);
        add(0,   0, 1, 0, 0, 4, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 1, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(1,  66, 1, 0, 1, 3, 1, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 2, 1, 0, 0);
        // Pause: contents kept, store still accepted, counter restarts.
        add(0,   0, 0, 0, 0, 2, 0, 0, 0);
        add(1,  77, 0, 0, 1, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 3, 0, 0, 0);
        add(0,   0, 1, 0, 0, 2, 1, 0, 0);
        add(0,   0, 1, 0, 0, 2, 0, 0, 0);
        add(0,   0, 1, 0, 0, 2, 0, 0, 0);
        add(0,   0, 1, 0, 0, 2, 0, 0, 0);
        add(0,   0, 1, 0, 0, 1, 1, 0, 0);
        add(0,   0, 1, 0, 0, 1, 0, 0, 0);
        add(0,   0, 1, 0, 0, 1, 0, 0, 0);
        add(0,   0, 1, 0, 0, 1, 0, 0, 0);
        add(0,   0, 1, 0, 0, 0, 1, 0, 0);
        // Drained: next wrap underruns.
        add(0,   0, 1, 0, 0, 0, 0, 0, 0);
        add(0,   0, 1, 0, 0, 0, 0, 0, 0);
        add(0,   0, 1, 0, 0, 0, 0, 0, 0);
        add(0,   0, 1, 0, 0, 0, 1, 0, 1);
        add(0,   0, 1, 1, 0, 0, 0, 0, 0);
        add(0,   0, 1, 0, 0, 0, 0, 0, 0);
        add(0,   0, 1, 0, 0, 0, 0, 0, 0);
        // Store coincident with an empty wrap: kept, underrun flagged.
        add(1,  88, 1, 0, 1, 1, 1, 0, 1);
        add(0,   0, 1, 1, 0, 1, 0, 0, 0);
        add(0,   0, 1, 0, 0, 1, 0, 0, 0);
        add(0,   0, 1, 0, 0, 1, 0, 0, 0);
        add(0,   0, 1, 0, 0, 0, 1, 0, 0);

        // Reset overrides a concurrent store.
        reset         = 1'b1;
        bus.wr_en     = 1'b1;
        bus.wr_data   = 10'd5;
        bus.enable    = 1'b1;
        bus.clr_flags = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check_status("reset", 0, 0, 0, 0);
        check("reset.duty", int'(bus.duty_cycle), 0);
        reset = 1'b0;
        do_cycle(0, 10'd0, 0, 0, 0);

        foreach (vecs[i]) begin
            do_cycle(vecs[i].wr, vecs[i].data, vecs[i].en, vecs[i].clr, vecs[i].push);
            check_status($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].tick,
                         vecs[i].ovf, vecs[i].und);
        end

        // clr_flags coincident with a new underrun: flag stays set.
        for (int i = 0; i < 3; i++) do_cycle(0, 10'd0, 1, 0, 0);
        do_cycle(0, 10'd0, 1, 1, 0);
        check("clr_vs_underrun.set", int'(bus.underrun), 1);
        do_cycle(0, 10'd0, 0, 1, 0);
        check("clr_vs_underrun.cleared", int'(bus.underrun), 0);

        // Full FIFO with a store on the wrap edge: both accepted.
        for (int i = 0; i < 4; i++) do_cycle(1, 10'(101 + i), 0, 0, 1);
        check("full_fill.level", int'(bus.level), 4);
        for (int i = 0; i < 3; i++) do_cycle(0, 10'd0, 1, 0, 0);
        do_cycle(1, 10'd105, 1, 0, 1);
        check_status("full_pop_push", 4, 1, 0, 0);
        for (int i = 0; i < 16; i++) do_cycle(0, 10'd0, 1, 0, 0);
        check("full_pop_push.drained", sb.size(), 0);
        check("full_pop_push.last_duty", int'(bus.duty_cycle), 105);
        check_status("full_pop_push.end", 0, 1, 0, 0);

        // Reset mid-period with three entries buffered.
        for (int i = 0; i < 3; i++) do_cycle(1, 10'(201 + i), 0, 0, 1);
        do_cycle(0, 10'd0, 1, 0, 0);
        do_cycle(0, 10'd0, 1, 0, 0);
        check("midreset.level_before", int'(bus.level), 3);
        reset = 1'b1;
        do_cycle(1, 10'd9, 1, 0, 0);
        sb.delete();
        last_duty = 0;
        check_status("midreset", 0, 0, 0, 0);
        check("midreset.duty", int'(bus.duty_cycle), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 10'd0, 1, 0, 0);
            check($sformatf("midreset.no_tick%0d", i), int'(bus.sample_tick), 0);
        end
        do_cycle(0, 10'd0, 1, 0, 0);
        check_status("midreset.first_wrap", 0, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
